// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: word-addressed store with a fixed-latency read pipeline
// and an in-order response queue; a credit count keeps the queue from overflowing.
module imem_fetch_responder #(
    parameter int          DEPTH_LOG2 = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          LATENCY    = 2,
    parameter int          QDEPTH     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_instr,
    output logic [31:0]           rsp_addr,
    output logic                  rsp_err,
    input  logic                  flush,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [31:0]           ld_data
);

    localparam int CW    = $clog2(QDEPTH + 1);
    localparam int PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int WORDS = 1 << DEPTH_LOG2;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [31:0]           store [WORDS];
    logic [31:0]           q_instr [QDEPTH];
    logic [31:0]           q_addr  [QDEPTH];
    logic [QDEPTH-1:0]     q_err;
    logic [31:0]           instr_p [LATENCY];
    logic [31:0]           addr_p  [LATENCY];
    logic [LATENCY-1:0]    err_p;

    logic [LATENCY-1:0]    vld_q, vld_d;
    logic [CW-1:0]         inflight_q, inflight_d;
    logic [CW-1:0]         qcount_q, qcount_d;
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;

    logic                  accept, acc_err, push, pop;
    logic [31:0]           word_off;
    logic [DEPTH_LOG2-1:0] word_idx;

    // Address check at accept; subtraction wraps so addresses below BASE_ADDR land out of range
    always_comb begin
        word_off = (req_addr - BASE_ADDR) >> 2;
        word_idx = word_off[DEPTH_LOG2-1:0];
        acc_err  = (req_addr[1:0] != 2'b00) || ((word_off >> DEPTH_LOG2) != 32'd0);
    end

    // Credits come from registered counts only, so req_ready never depends on req_valid
    assign req_ready = rst & ~flush & ~ld_en &
                       (({1'b0, inflight_q} + {1'b0, qcount_q}) < (CW + 1)'(QDEPTH));
    assign accept    = req_valid & req_ready;
    assign push      = vld_q[LATENCY-1];
    assign rsp_valid = (qcount_q != '0);
    assign pop       = rsp_valid & rsp_ready;

    assign rsp_instr = rsp_valid ? q_instr[rptr_q] : '0;
    assign rsp_addr  = rsp_valid ? q_addr[rptr_q]  : '0;
    assign rsp_err   = rsp_valid ? q_err[rptr_q]   : 1'b0;

    always_comb begin
        vld_d      = '0;
        inflight_d = inflight_q;
        qcount_d   = qcount_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        if (flush) begin
            inflight_d = '0;
            qcount_d   = '0;
            wptr_d     = '0;
            rptr_d     = '0;
        end else begin
            vld_d[0] = accept;
            for (int i = 1; i < LATENCY; i++) begin
                vld_d[i] = vld_q[i-1];
            end
            inflight_d = inflight_q + CW'(accept) - CW'(push);
            qcount_d   = qcount_q + CW'(push) - CW'(pop);
            if (push) wptr_d = ptr_inc(wptr_q);
            if (pop)  rptr_d = ptr_inc(rptr_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q      <= '0;
            inflight_q <= '0;
            qcount_q   <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            vld_q      <= vld_d;
            inflight_q <= inflight_d;
            qcount_q   <= qcount_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    // Stage 1 reads the store; later stages only delay. Entries are qualified by vld_q.
    always_ff @(posedge clk) begin
        if (ld_en) store[ld_addr] <= ld_data;
        instr_p[0] <= (accept && !acc_err) ? store[word_idx] : '0;
        addr_p[0]  <= req_addr;
        err_p[0]   <= acc_err;
        for (int i = 1; i < LATENCY; i++) begin
            instr_p[i] <= instr_p[i-1];
            addr_p[i]  <= addr_p[i-1];
            err_p[i]   <= err_p[i-1];
        end
        if (push && !flush) begin
            q_instr[wptr_q] <= instr_p[LATENCY-1];
            q_addr[wptr_q]  <= addr_p[LATENCY-1];
            q_err[wptr_q]   <= err_p[LATENCY-1];
        end
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: directed scenarios plus random traffic against a
// transaction-level model (memory image + queue of outstanding fetches with accept times).
module tb_imem_fetch_responder;

    localparam int          DL   = 8;
    localparam int          LAT  = 2;
    localparam int          QD   = 4;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready;
    logic [31:0]   req_addr;
    logic          rsp_valid, rsp_ready;
    logic [31:0]   rsp_instr, rsp_addr;
    logic          rsp_err;
    logic          flush, ld_en;
    logic [DL-1:0] ld_addr;
    logic [31:0]   ld_data;

    imem_fetch_responder #(
        .DEPTH_LOG2(DL), .BASE_ADDR(BASE), .LATENCY(LAT), .QDEPTH(QD)
    ) dut (
        .clk(clk), .rst(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
        .rsp_addr(rsp_addr), .rsp_err(rsp_err),
        .flush(flush), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
        int unsigned acc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mem_m [1 << DL];
    int unsigned cyc;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic bit head_vis();
        return (mq.size() != 0) && (cyc >= mq[0].acc + LAT);
    endfunction

    function automatic bit exp_ready();
        return rst_n && !flush && !ld_en && (mq.size() < QD);
    endfunction

    function automatic ent_t make_ent(input logic [31:0] a);
        ent_t        e;
        logic [31:0] w;
        w       = (a - BASE) >> 2;
        e.addr  = a;
        e.err   = (a[1:0] != 2'b00) || (w >= (1 << DL));
        e.instr = e.err ? 32'h0 : mem_m[w[DL-1:0]];
        e.acc   = 0;
        return e;
    endfunction

    task automatic compare_all();
        chk("rsp_valid", rsp_valid, head_vis());
        chk("req_ready", req_ready, exp_ready());
        if (head_vis()) begin
            chk("rsp_addr",  rsp_addr,  mq[0].addr);
            chk("rsp_instr", rsp_instr, mq[0].instr);
            chk("rsp_err",   rsp_err,   mq[0].err);
        end
    endtask

    // One clock: decide what the edge does from the current inputs, apply it to the model,
    // then compare everything at the following negedge.
    task automatic cycle();
        bit            acc, pop, fl, le;
        logic [DL-1:0] la;
        logic [31:0]   ld;
        ent_t          e;
        acc = req_valid && exp_ready();
        pop = head_vis() && rsp_ready;
        fl  = flush;
        le  = ld_en;
        la  = ld_addr;
        ld  = ld_data;
        e   = make_ent(req_addr);
        @(posedge clk);
        cyc++;
        if (!rst_n || fl) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) begin
                e.acc = cyc;
                mq.push_back(e);
            end
        end
        if (le) mem_m[la] = ld;
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return ($urandom_range(0, 255) << 2) | 32'($urandom_range(1, 3));
        if (r == 1) return $urandom_range(256, 65535) << 2;
        return $urandom_range(0, 255) << 2;
    endfunction

    initial begin
        cyc       = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        flush     = 1'b0;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        #1;
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_instr", rsp_instr, 32'h0);
        chk("rst_rsp_addr",  rsp_addr,  32'h0);
        chk("rst_rsp_err",   rsp_err,   1'b0);
        chk("rst_req_ready", req_ready, 1'b0);
        @(negedge clk);
        cycle();
        cycle();
        rst_n = 1'b1;
        #1 chk("ready_after_rst", req_ready, 1'b1);

        // Preload the store; word 5 gets a known instruction
        for (int i = 0; i < (1 << DL); i++) begin
            ld_en   = 1'b1;
            ld_addr = DL'(i);
            ld_data = (i == 5) ? 32'h2008_0007 : $urandom;
            cycle();
        end
        ld_en = 1'b0;

        // Single fetch of word 5
        req_valid = 1'b1;
        req_addr  = 32'h14;
        cycle();
        req_valid = 1'b0;
        cycle();
        cycle();
        chk("single_vld",   rsp_valid, 1'b1);
        chk("single_instr", rsp_instr, 32'h2008_0007);
        chk("single_addr",  rsp_addr,  32'h14);
        chk("single_err",   rsp_err,   1'b0);
        rsp_ready = 1'b1;
        cycle();

        // Stall until full, then drain in order
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'b1;
            req_addr  = 32'(k * 4);
            cycle();
        end
        req_valid = 1'b0;
        #1 chk("full_ready", req_ready, 1'b0);
        cycle();
        cycle();
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_order", rsp_addr, 32'(k * 4));
            cycle();
        end
        chk("ready_after_drain", req_ready, 1'b1);

        // Misaligned and out-of-range fetches followed by a good one
        req_valid = 1'b1; req_addr = 32'h6;   cycle();
        req_addr  = 32'h400;                  cycle();
        req_addr  = 32'h8;                    cycle();
        req_valid = 1'b0;
        chk("mis_err",   rsp_err,   1'b1);
        chk("mis_instr", rsp_instr, 32'h0);
        chk("mis_addr",  rsp_addr,  32'h6);
        cycle();
        chk("oor_err",  rsp_err,  1'b1);
        chk("oor_addr", rsp_addr, 32'h400);
        cycle();
        chk("good_err",   rsp_err,   1'b0);
        chk("good_addr",  rsp_addr,  32'h8);
        chk("good_instr", rsp_instr, mem_m[2]);
        cycle();

        // Flush with two queued and two in flight
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'b1;
            req_addr  = 32'h20 + 32'(k * 4);
            cycle();
        end
        req_valid = 1'b0;
        flush     = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_vld", rsp_valid, 1'b0);
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("flush_stale", rsp_valid, 1'b0);
            cycle();
        end
        req_valid = 1'b1;
        req_addr  = 32'h10;
        cycle();
        req_valid = 1'b0;
        cycle();
        cycle();
        chk("post_flush_vld",   rsp_valid, 1'b1);
        chk("post_flush_addr",  rsp_addr,  32'h10);
        chk("post_flush_instr", rsp_instr, mem_m[4]);
        cycle();

        // Load interlock
        ld_en     = 1'b1;
        ld_addr   = DL'(9);
        ld_data   = 32'hCAFE_0009;
        req_valid = 1'b1;
        req_addr  = 32'h24;
        for (int k = 0; k < 3; k++) begin
            #1 chk("ld_block", req_ready, 1'b0);
            cycle();
        end
        ld_en = 1'b0;
        #1 chk("ld_release", req_ready, 1'b1);
        cycle();
        req_valid = 1'b0;
        cycle();
        cycle();
        chk("ld_new_instr", rsp_instr, 32'hCAFE_0009);
        chk("ld_new_addr",  rsp_addr,  32'h24);
        cycle();

        // Asynchronous reset in the middle of traffic
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_valid = 1'b1;
            req_addr  = 32'h40 + 32'(k * 4);
            cycle();
        end
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        mq.delete();
        chk("mid_rst_vld",   rsp_valid, 1'b0);
        chk("mid_rst_ready", req_ready, 1'b0);
        chk("mid_rst_addr",  rsp_addr,  32'h0);
        @(negedge clk);
        cycle();
        cycle();
        rst_n = 1'b1;
        #1 chk("mid_rst_release", req_ready, 1'b1);
        rsp_ready = 1'b1;
        repeat (4) cycle();

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = rand_addr();
            rsp_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            cycle();
        end
        req_valid = 1'b0;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        repeat (8) cycle();
        chk("final_empty", rsp_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
- Instruction-memory responder at the far end of the fetch path: accepts fetch addresses from the program-counter side, returns 32-bit instruction words.
- Holds a synchronous word-addressed instruction store, loaded through a separate load port.
- Returns responses in order after a fixed pipeline latency, with a response queue and backpressure on both sides.
- Flags misaligned and out-of-range fetches instead of returning data.

Parameters:
- DEPTH_LOG2, 8, log2 of instruction store size in 32-bit words (256 words).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.
- LATENCY, 2, cycles from request accept to response entering the queue; legal 1..4.
- QDEPTH, 4, response queue depth and the maximum number of requests in flight plus queued; must be >= LATENCY.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-low.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  fetch byte address.
- rsp_valid  out  1  response at queue head valid.
- rsp_ready  in  1  consumer takes the response.
- rsp_instr  out  32  instruction word; 0 when rsp_err=1.
- rsp_addr  out  32  byte address of the request this response belongs to.
- rsp_err  out  1  1 = misaligned or out-of-range fetch.
- flush  in  1  discard all in-flight and queued responses.
- ld_en  in  1  write ld_data into the store.
- ld_addr  in  DEPTH_LOG2  word index to load.
- ld_data  in  32  word to load.

Behaviour:
- **Reset** (rst=0, asynchronous):
  - rsp_valid=0, rsp_instr=0, rsp_addr=0, rsp_err=0.
  - Pipeline valid bits cleared; in-flight and queue counts = 0; queue pointers = 0.
  - req_ready=0 while rst=0.
  - Store contents are not reset.
- **Accept:**
  - A request is accepted on a posedge with req_valid=1 and req_ready=1.
  - req_ready = rst & !flush & !ld_en & ((inflight + qcount) < QDEPTH).
  - req_ready is combinational from registered counts only; it never depends on req_valid.
- **Address check** (at accept; word = (req_addr - BASE_ADDR) >> 2, 32-bit unsigned wrap):
  - Misaligned when req_addr[1:0] != 0.
  - Out of range when word >= 2**DEPTH_LOG2.
  - Either condition -> err=1 and instr forced to 0. The store is not read for error requests.
- **Latency:**
  - A request accepted at edge N enters the queue at edge N+LATENCY.
  - It is visible on rsp_* in the same cycle it enters the queue when the queue was empty.
  - One request per cycle can be accepted back-to-back.
- **Queue:**
  - In-order FIFO of {instr, addr, err}.
  - A pop happens on an edge with rsp_valid=1 and rsp_ready=1.
  - rsp_valid = (qcount != 0).
  - Pointers wrap modulo QDEPTH.
  - Push and pop on the same edge leave qcount unchanged.
  - Overflow is impossible by construction of req_ready. Any push attempted at qcount==QDEPTH is a design bug; verification asserts it never happens.
- **Counts:**
  - inflight increments on accept and decrements on push into the queue. Both on the same edge leave it unchanged.
- **Flush** (sampled at posedge):
  - Clears all pipeline valid bits, qcount=0, pointers=0, inflight=0.
  - rsp_valid=0 from the next cycle.
  - A pop and push on the flush edge are both discarded.
  - req_ready=0 during flush, so no accept occurs on that edge.
- **Load:**
  - On a posedge with ld_en=1, store[ld_addr] <= ld_data.
  - req_ready=0 while ld_en=1.
  - Requests already in flight that read the loaded word return old or new data depending on pipeline position. Software flushes after loading; the bench does not check this case.
- **Read path:**
  - Synchronous store read in pipeline stage 1.
  - Remaining LATENCY-1 stages are pure delay registers carrying {valid, instr, addr, err}.
  - Stages advance unconditionally; backpressure is absorbed only by the queue, guaranteed by the credit rule.

Test Plan:
- **Reset/idle:** assert rst=0 mid-traffic with 3 requests in flight -> rsp_valid=0 and req_ready=0 immediately. After release: req_ready=1, no stale responses appear.
- **Single fetch:** load word 5 = 32'h2008_0007; request 0x14 at edge N -> rsp_valid=1 at edge N+2 with rsp_instr=32'h2008_0007, rsp_addr=0x14, rsp_err=0.
- **Stall to full:** rsp_ready=0; issue 0x0, 0x4, 0x8, 0xC back-to-back -> req_ready drops after the 4th accept. Raise rsp_ready -> 4 responses in address order, then req_ready=1.
- **Errors:** request 0x6 -> rsp_err=1, rsp_instr=0, rsp_addr=0x6. Request 0x400 (DEPTH_LOG2=8) -> rsp_err=1. A following 0x8 returns valid data with no ordering slip.
- **Flush:** 2 in flight plus 2 queued, pulse flush 1 cycle -> rsp_valid=0 next cycle, none of the 4 responses ever appear. A new request 0x10 returns in 2 cycles.
- **Load interlock:** hold ld_en=1 with req_valid=1 -> req_ready=0 throughout. Release -> request accepted on the next edge and returns the newly loaded word.
